// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI frame scheduler and its slave-side model:
//   - sched_state_e   : scheduler FSM states (IDLE/EXEC/WAIT/GAP)
//   - CTRL_*_DFLT     : default control codes for write and read frames
//   - frame_width()   : total frame width for a given field geometry
//   - frame_field_lsb(): bit offset of each frame field, so master and slave
//                        agree on the layout without duplicating arithmetic
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } sched_state_e;

    typedef enum logic [1:0] {
        FIELD_CTRL    = 2'd0,
        FIELD_ADDR    = 2'd1,
        FIELD_PAYLOAD = 2'd2
    } frame_field_e;

    localparam logic [7:0] CTRL_WRITE_DFLT = 8'h3a;
    localparam logic [7:0] CTRL_READ_DFLT  = 8'h3b;

    // Encoding of the round-robin history flag.
    localparam logic LAST_GRANT_WR = 1'b0;
    localparam logic LAST_GRANT_RD = 1'b1;

    function automatic int frame_width(input int ctrl_w, input int addr_w,
                                       input int payload_bytes);
        return ctrl_w + addr_w + (32'sd8 * payload_bytes);
    endfunction

    // Frame is {ctrl, addr, payload}, MSB first, so the payload sits at bit 0.
    function automatic int frame_field_lsb(input frame_field_e field,
                                           input int addr_w,
                                           input int payload_bytes);
        int lsb;
        case (field)
            FIELD_CTRL:    lsb = addr_w + (32'sd8 * payload_bytes);
            FIELD_ADDR:    lsb = 32'sd8 * payload_bytes;
            FIELD_PAYLOAD: lsb = 32'sd0;
            default:       lsb = 32'sd0;
        endcase
        return lsb;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter (requester 0 = write, 1 = read).
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   req_wr/req_rd: request inputs
//   update       : commit the current grant into the history flag
//   gnt[1:0]     : combinational one-hot grant (bit0 write, bit1 read)
// A lone request always wins; a tie goes to the side not granted last.
// The history flag resets to "read" so write wins the first tie.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import spi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       req_wr,
    input  logic       req_rd,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection and history update.
    always_comb begin
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        if (req_wr && req_rd) begin
            if (last_grant_q == LAST_GRANT_RD) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else if (req_wr) begin
            gnt = 2'b01;
        end else if (req_rd) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end

        if (update && gnt[1]) begin
            last_grant_d = LAST_GRANT_RD;
        end else if (update && gnt[0]) begin
            last_grant_d = LAST_GRANT_WR;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // History flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= LAST_GRANT_RD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/spi_frame_scheduler.sv
// -----------------------------------------------------------------------------
// spi_frame_scheduler
// Shares one SPI master frame port between a write-burst and a read-burst
// requester. Builds the {ctrl, addr, payload} frame, launches it with a
// one-cycle spi_exe, waits for spi_done (or aborts after TIMEOUT_CYCLES),
// then enforces GAP_CYCLES idle clocks before the next grant.
// Ports:
//   clock, reset            : system clock, asynchronous active-high reset
//   enable                  : permits new grants (in-flight frames continue)
//   wr_req/wr_addr/wr_data  : write request, held until wr_ack
//   wr_ack/wr_done          : grant and completion pulses for the writer
//   rd_req/rd_addr          : read request, held until rd_ack
//   rd_ack/rd_done          : grant and completion pulses for the reader
//   spi_exe/spi_tx_data     : frame start pulse and frame to the master
//   spi_done                : frame-complete pulse from the master
//   busy                    : scheduler is not IDLE
//   timeout                 : pulse when a frame is aborted
// All outputs are registered.
// -----------------------------------------------------------------------------
module spi_frame_scheduler
    import spi_pkg::*;
#(
    parameter int CTRL_WIDTH     = 32'sd8,
    parameter int ADDR_WIDTH     = 32'sd32,
    parameter int PAYLOAD_BYTES  = 32'sd64,
    parameter logic [CTRL_WIDTH-1:0] CTRL_WRITE = CTRL_WIDTH'(CTRL_WRITE_DFLT),
    parameter logic [CTRL_WIDTH-1:0] CTRL_READ  = CTRL_WIDTH'(CTRL_READ_DFLT),
    parameter int GAP_CYCLES     = 32'sd4,
    parameter int TIMEOUT_CYCLES = 32'sd65535,
    localparam int PAYLOAD_W     = 32'sd8 * PAYLOAD_BYTES,
    localparam int FRAME_WIDTH   = frame_width(CTRL_WIDTH, ADDR_WIDTH, PAYLOAD_BYTES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   wr_req,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [PAYLOAD_W-1:0]   wr_data,
    output logic                   wr_ack,
    output logic                   wr_done,
    input  logic                   rd_req,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   rd_ack,
    output logic                   rd_done,
    output logic                   spi_exe,
    output logic [FRAME_WIDTH-1:0] spi_tx_data,
    input  logic                   spi_done,
    output logic                   busy,
    output logic                   timeout
);

    localparam int CTRL_LSB    = frame_field_lsb(FIELD_CTRL, ADDR_WIDTH, PAYLOAD_BYTES);
    localparam int ADDR_LSB    = frame_field_lsb(FIELD_ADDR, ADDR_WIDTH, PAYLOAD_BYTES);
    localparam int PAYLOAD_LSB = frame_field_lsb(FIELD_PAYLOAD, ADDR_WIDTH, PAYLOAD_BYTES);

    localparam bit GAP_EN = (GAP_CYCLES != 32'sd0);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 32'sd0);

    // Gap counter walks 0..GAP_CYCLES-1; timeout counter is $clog2(T+1) wide.
    localparam int GAP_W = (GAP_CYCLES > 32'sd1) ? $clog2(GAP_CYCLES) : 32'sd1;
    localparam int TMO_W = TMO_EN ? $clog2(TIMEOUT_CYCLES + 32'sd1) : 32'sd1;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 32'sd1);
    localparam logic [GAP_W-1:0] GAP_INC  = GAP_W'(1'b1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'sd1);
    localparam logic [TMO_W-1:0] TMO_INC  = TMO_W'(1'b1);

    sched_state_e           state_q, state_d;
    logic                   wr_ack_q, wr_ack_d;
    logic                   rd_ack_q, rd_ack_d;
    logic                   wr_done_q, wr_done_d;
    logic                   rd_done_q, rd_done_d;
    logic                   spi_exe_q, spi_exe_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;
    logic                   grant_rd_q, grant_rd_d;
    logic [FRAME_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

    logic [FRAME_WIDTH-1:0] wr_frame_s;
    logic [FRAME_WIDTH-1:0] rd_frame_s;
    logic                   arb_update_s;
    logic [1:0]             arb_gnt_s;

    rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req_wr (wr_req),
        .req_rd (rd_req),
        .update (arb_update_s),
        .gnt    (arb_gnt_s)
    );

    // Frame assembly for both requesters; read frames carry a zero payload.
    always_comb begin
        wr_frame_s = '0;
        rd_frame_s = '0;
        wr_frame_s[CTRL_LSB +: CTRL_WIDTH]   = CTRL_WRITE;
        wr_frame_s[ADDR_LSB +: ADDR_WIDTH]   = wr_addr;
        wr_frame_s[PAYLOAD_LSB +: PAYLOAD_W] = wr_data;
        rd_frame_s[CTRL_LSB +: CTRL_WIDTH]   = CTRL_READ;
        rd_frame_s[ADDR_LSB +: ADDR_WIDTH]   = rd_addr;
    end

    // Scheduler next-state, counters and output pulses.
    always_comb begin
        state_d      = state_q;
        wr_ack_d     = 1'b0;
        rd_ack_d     = 1'b0;
        wr_done_d    = 1'b0;
        rd_done_d    = 1'b0;
        spi_exe_d    = 1'b0;
        timeout_d    = 1'b0;
        grant_rd_d   = grant_rd_q;
        tx_data_d    = tx_data_q;
        tmo_cnt_d    = tmo_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        arb_update_s = (state_q == IDLE) && enable && (wr_req || rd_req);

        case (state_q)
            IDLE: begin
                if (enable && arb_gnt_s[0]) begin
                    state_d    = EXEC;
                    wr_ack_d   = 1'b1;
                    spi_exe_d  = 1'b1;
                    grant_rd_d = 1'b0;
                    tx_data_d  = wr_frame_s;
                end else if (enable && arb_gnt_s[1]) begin
                    state_d    = EXEC;
                    rd_ack_d   = 1'b1;
                    spi_exe_d  = 1'b1;
                    grant_rd_d = 1'b1;
                    tx_data_d  = rd_frame_s;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d   = WAIT;
                tmo_cnt_d = '0;
            end
            WAIT: begin
                // A done arriving on the expiry edge still counts as done.
                if (spi_done) begin
                    wr_done_d = ~grant_rd_q;
                    rd_done_d = grant_rd_q;
                    state_d   = GAP_EN ? GAP : IDLE;
                    gap_cnt_d = '0;
                end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = GAP_EN ? GAP : IDLE;
                    gap_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_INC;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_INC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            spi_exe_q  <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            grant_rd_q <= 1'b0;
            tx_data_q  <= '0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            spi_exe_q  <= spi_exe_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            grant_rd_q <= grant_rd_d;
            tx_data_q  <= tx_data_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign wr_ack      = wr_ack_q;
    assign rd_ack      = rd_ack_q;
    assign wr_done     = wr_done_q;
    assign rd_done     = rd_done_q;
    assign spi_exe     = spi_exe_q;
    assign spi_tx_data = tx_data_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_scheduler
// Directed bench for spi_frame_scheduler (GAP_CYCLES=4, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spi_frame_scheduler;

    localparam int FW = 552;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          wr_req;
    logic [31:0]   wr_addr;
    logic [511:0]  wr_data;
    logic          wr_ack;
    logic          wr_done;
    logic          rd_req;
    logic [31:0]   rd_addr;
    logic          rd_ack;
    logic          rd_done;
    logic          spi_exe;
    logic [FW-1:0] spi_tx_data;
    logic          spi_done;
    logic          busy;
    logic          timeout;

    int            tests;
    int            failed;
    int            n;
    logic          seen;
    logic [511:0]  pay_inc;
    logic [511:0]  pay_pat;
    logic [FW-1:0] exp_frame;

    spi_frame_scheduler #(
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .wr_done     (wr_done),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_done     (rd_done),
        .spi_exe     (spi_exe),
        .spi_tx_data (spi_tx_data),
        .spi_done    (spi_done),
        .busy        (busy),
        .timeout     (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for spi_exe; cycles = falling edges waited.
    task automatic wait_exe(output int cycles);
        cycles = 0;
        while (spi_exe !== 1'b1 && cycles < 100) begin
            @(negedge clock);
            cycles++;
        end
        check_bit("exe_seen", spi_exe, 1'b1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 100) begin
            @(negedge clock);
            c++;
        end
        check_bit("idle_reached", busy, 1'b0);
    endtask

    // Called in the EXEC cycle; answers with spi_done and checks the done pulses.
    task automatic finish_frame(input logic exp_wr, input logic exp_rd, input string tag);
        @(negedge clock);
        @(negedge clock);
        spi_done = 1'b1;
        @(negedge clock);
        spi_done = 1'b0;
        check_bit({tag, "_wr_done"}, wr_done, exp_wr);
        check_bit({tag, "_rd_done"}, rd_done, exp_rd);
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        spi_done = 1'b0;
        wr_addr  = 32'h0;
        rd_addr  = 32'h0;
        wr_data  = '0;
        for (int i = 0; i < 64; i++) pay_inc[8*i +: 8] = 8'(i);
        pay_pat = {16{32'hdeadbeef}};

        // Reset state
        repeat (3) @(negedge clock);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_exe", spi_exe, 1'b0);
        check_bit("rst_wr_ack", wr_ack, 1'b0);
        check_bit("rst_rd_ack", rd_ack, 1'b0);
        check_bit("rst_timeout", timeout, 1'b0);
        check_vec("rst_tx", spi_tx_data, '0);
        reset  = 1'b0;
        enable = 1'b1;

        // Single write, payload bytes 0..63
        wr_addr = 32'h0;
        wr_data = pay_inc;
        wr_req  = 1'b1;
        @(negedge clock);
        check_bit("w1_ack", wr_ack, 1'b1);
        check_bit("w1_rd_ack", rd_ack, 1'b0);
        check_bit("w1_exe", spi_exe, 1'b1);
        check_bit("w1_busy", busy, 1'b1);
        exp_frame = {8'h3a, 32'h0, pay_inc};
        check_vec("w1_frame", spi_tx_data, exp_frame);
        check_int("w1_ctrl", int'(spi_tx_data[551:544]), 32'h3a);
        check_int("w1_addr", int'(spi_tx_data[543:512]), 0);
        check_int("w1_byte0", int'(spi_tx_data[7:0]), 0);
        check_int("w1_byte63", int'(spi_tx_data[511:504]), 63);
        wr_req = 1'b0;
        finish_frame(1'b1, 1'b0, "w1");
        @(negedge clock);
        check_bit("w1_done_one_cycle", wr_done, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check_bit("w1_gap_busy", busy, 1'b1);
        @(negedge clock);
        check_bit("w1_gap_end_idle", busy, 1'b0);
        check_vec("w1_frame_stable", spi_tx_data, exp_frame);

        // Single read at 0x40
        rd_addr = 32'h40;
        rd_req  = 1'b1;
        @(negedge clock);
        check_bit("r1_ack", rd_ack, 1'b1);
        check_bit("r1_wr_ack", wr_ack, 1'b0);
        check_bit("r1_exe", spi_exe, 1'b1);
        exp_frame = {8'h3b, 32'h40, 512'h0};
        check_vec("r1_frame", spi_tx_data, exp_frame);
        rd_req = 1'b0;
        finish_frame(1'b0, 1'b1, "r1");
        wait_idle();

        // spi_done while idle is ignored
        spi_done = 1'b1;
        @(negedge clock);
        spi_done = 1'b0;
        check_bit("idle_done_wr", wr_done, 1'b0);
        check_bit("idle_done_rd", rd_done, 1'b0);
        check_bit("idle_done_busy", busy, 1'b0);

        // Both requesters held: W,R,W,R with done-to-exe spacing of GAP+1
        wr_addr = 32'h100;
        rd_addr = 32'h200;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_exe(n);
            if (f > 0) check_int("rr_spacing", n, 5);
            check_bit("rr_wr_ack", wr_ack, (f % 2 == 0) ? 1'b1 : 1'b0);
            check_bit("rr_rd_ack", rd_ack, (f % 2 == 0) ? 1'b0 : 1'b1);
            check_int("rr_ctrl", int'(spi_tx_data[551:544]), (f % 2 == 0) ? 32'h3a : 32'h3b);
            finish_frame((f % 2 == 0) ? 1'b1 : 1'b0, (f % 2 == 0) ? 1'b0 : 1'b1, "rr");
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        wait_idle();

        // Missing spi_done: timeout 17 clocks after spi_exe, then serve a read
        wr_addr = 32'h300;
        wr_req  = 1'b1;
        wait_exe(n);
        check_bit("to_wr_ack", wr_ack, 1'b1);
        wr_req  = 1'b0;
        rd_addr = 32'h400;
        rd_req  = 1'b1;
        seen    = 1'b0;
        repeat (16) begin
            @(negedge clock);
            if (timeout || wr_done || rd_done) seen = 1'b1;
        end
        check_bit("to_not_early", seen, 1'b0);
        @(negedge clock);
        check_bit("to_pulse", timeout, 1'b1);
        check_bit("to_no_wr_done", wr_done, 1'b0);
        check_bit("to_no_rd_done", rd_done, 1'b0);
        @(negedge clock);
        check_bit("to_one_cycle", timeout, 1'b0);
        wait_exe(n);
        check_int("to_next_spacing", n, 4);
        check_bit("to_next_rd_ack", rd_ack, 1'b1);
        check_int("to_next_addr", int'(spi_tx_data[543:512]), 32'h400);
        rd_req = 1'b0;
        finish_frame(1'b0, 1'b1, "to_rd");
        wait_idle();

        // enable low blocks grants; dropping it mid-frame does not abort
        enable  = 1'b0;
        wr_addr = 32'h500;
        wr_req  = 1'b1;
        seen    = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (wr_ack || rd_ack || spi_exe) seen = 1'b1;
        end
        check_bit("en_no_grant", seen, 1'b0);
        check_bit("en_idle", busy, 1'b0);
        enable = 1'b1;
        @(negedge clock);
        check_bit("en_ack", wr_ack, 1'b1);
        check_bit("en_exe", spi_exe, 1'b1);
        wr_req = 1'b0;
        enable = 1'b0;
        finish_frame(1'b1, 1'b0, "en_mid");
        enable = 1'b1;
        wait_idle();

        // Reset mid-WAIT with both requests pending; write must win the tie after reset
        wr_addr = 32'h600;
        wr_data = pay_inc;
        wr_req  = 1'b1;
        wait_exe(n);
        check_bit("rs_pre_ack", wr_ack, 1'b1);
        wr_req = 1'b0;
        @(negedge clock);
        wr_addr = 32'h80;
        wr_data = pay_pat;
        rd_addr = 32'h44;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        @(negedge clock);
        check_bit("rs_in_wait_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("rs_busy", busy, 1'b0);
        check_bit("rs_exe", spi_exe, 1'b0);
        check_bit("rs_wr_ack", wr_ack, 1'b0);
        check_bit("rs_rd_ack", rd_ack, 1'b0);
        check_bit("rs_wr_done", wr_done, 1'b0);
        check_bit("rs_timeout", timeout, 1'b0);
        check_vec("rs_tx", spi_tx_data, '0);
        @(negedge clock);
        spi_done = 1'b1;
        @(negedge clock);
        spi_done = 1'b0;
        check_bit("rs_held_exe", spi_exe, 1'b0);
        check_bit("rs_held_done", wr_done, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check_bit("rs_post_wr_ack", wr_ack, 1'b1);
        check_bit("rs_post_rd_ack", rd_ack, 1'b0);
        check_bit("rs_post_exe", spi_exe, 1'b1);
        exp_frame = {8'h3a, 32'h80, pay_pat};
        check_vec("rs_post_frame", spi_tx_data, exp_frame);
        wr_req = 1'b0;
        finish_frame(1'b1, 1'b0, "rs_post");
        wait_exe(n);
        check_int("rs_rd_spacing", n, 5);
        check_bit("rs_rd_ack", rd_ack, 1'b1);
        exp_frame = {8'h3b, 32'h44, 512'h0};
        check_vec("rs_rd_frame", spi_tx_data, exp_frame);
        rd_req = 1'b0;
        finish_frame(1'b0, 1'b1, "rs_rd");
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
